counter_johnson_param: RTL

Parametrised up/down Johnson (twisted-ring) counter: the next generation of the 3-bit up/down Johnson counter, generalised to any width. It adds count enable, synchronous load by state index, a binary index output, a wrap pulse, and self-recovery from illegal ring states. It is intended as a drop-in sequencer/phase generator wherever the fixed 3-bit counter is used today.

---
 rtl/counter_johnson_param.sv | 121 ++++++++++++
 1 files changed

// File: rtl/counter_johnson_param.sv
// Purpose: parametrised up/down Johnson (twisted-ring) counter with enable, load-by-index,
//          binary index output, wrap/load-error/illegal pulses and one-edge illegal-state recovery.
// Latency: one cycle, all outputs registered. Backpressure: none; enable_i=0 simply holds state.
//
// Ports:
//   clock_i        rising-edge clock
//   reset_i        synchronous active-high reset
//   enable_i       count enable (0 holds)
//   up_down_i      direction, 0 = up, 1 = down
//   load_i         synchronous load request
//   load_index_i   target state index for load, valid 0..2*WIDTH-1
//   out_o          Johnson code of current state
//   index_o        binary index of current state
//   wrap_o         one-cycle pulse when the count crosses 2*WIDTH-1 <-> 0
//   load_err_o     one-cycle pulse when a load targets an out-of-range index
//   illegal_o      one-cycle pulse when an illegal ring state was cleared
module counter_johnson_param #(
    parameter int WIDTH = 3,
    localparam int IDXW = $clog2(2 * WIDTH)
) (
    input  logic            clock_i,
    input  logic            reset_i,
    input  logic            enable_i,
    input  logic            up_down_i,
    input  logic            load_i,
    input  logic [IDXW-1:0] load_index_i,
    output logic [WIDTH-1:0] out_o,
    output logic [IDXW-1:0] index_o,
    output logic            wrap_o,
    output logic            load_err_o,
    output logic            illegal_o
);

    localparam logic [IDXW-1:0] LAST_IDX = IDXW'(2 * WIDTH - 1);

    logic [WIDTH-1:0] out_q, out_d;
    logic [IDXW-1:0]  idx_q, idx_d;
    logic             wrap_q, wrap_d;
    logic             lerr_q, lerr_d;
    logic             ill_q, ill_d;

    logic             code_legal;
    logic             load_in_range;

    // Johnson code for state index k: k<=WIDTH gives k low-order ones, otherwise
    // all ones with (k-WIDTH) low-order zeros.
    function automatic logic [WIDTH-1:0] code_of(input logic [IDXW-1:0] k);
        logic [WIDTH-1:0] c;
        int kk;
        c  = '0;
        kk = int'(k);
        for (int i = 0; i < WIDTH; i++) begin
            if (kk <= WIDTH) c[i] = (i < kk);
            else             c[i] = (i >= kk - WIDTH);
        end
        return c;
    endfunction

    // A legal ring word has at most one boundary between adjacent bits.
    always_comb begin
        logic [WIDTH-2:0] edges;
        edges      = out_q[WIDTH-1:1] ^ out_q[WIDTH-2:0];
        code_legal = ($countones(edges) <= 1);
    end

    assign load_in_range = (int'(load_index_i) < 2 * WIDTH);

    always_comb begin
        out_d  = out_q;
        idx_d  = idx_q;
        wrap_d = 1'b0;
        lerr_d = 1'b0;
        ill_d  = 1'b0;
        if (load_i) begin
            if (load_in_range) begin
                out_d = code_of(load_index_i);
                idx_d = load_index_i;
            end else begin
                lerr_d = 1'b1;
            end
        end else if (!code_legal) begin
            // Recovery takes precedence over counting so index never tracks a corrupt code.
            out_d = '0;
            idx_d = '0;
            ill_d = 1'b1;
        end else if (enable_i) begin
            if (!up_down_i) begin
                out_d  = {out_q[WIDTH-2:0], ~out_q[WIDTH-1]};
                idx_d  = (idx_q == LAST_IDX) ? '0 : idx_q + IDXW'(1);
                wrap_d = (idx_q == LAST_IDX);
            end else begin
                out_d  = {~out_q[0], out_q[WIDTH-1:1]};
                idx_d  = (idx_q == '0) ? LAST_IDX : idx_q - IDXW'(1);
                wrap_d = (idx_q == '0);
            end
        end
    end

    always_ff @(posedge clock_i) begin
        if (reset_i) begin
            out_q  <= '0;
            idx_q  <= '0;
            wrap_q <= 1'b0;
            lerr_q <= 1'b0;
            ill_q  <= 1'b0;
        end else begin
            out_q  <= out_d;
            idx_q  <= idx_d;
            wrap_q <= wrap_d;
            lerr_q <= lerr_d;
            ill_q  <= ill_d;
        end
    end

    assign out_o      = out_q;
    assign index_o    = idx_q;
    assign wrap_o     = wrap_q;
    assign load_err_o = lerr_q;
    assign illegal_o  = ill_q;

endmodule
